// File: rtl/freq_meas_pkg.sv
// ---------------------------------------------------------------------------
// freq_meas_pkg
//
// Shared definitions for the frequency-measurement sequencer:
//   - Wishbone register map of the frequency counter slave
//   - control register bit positions and the command words built from them
//   - error codes reported on error_o
//   - per-transfer status returned by wb_single_xfer
//   - sequencer state enum and a helper that says which states use the bus
// ---------------------------------------------------------------------------
package freq_meas_pkg;

    // Slave register addresses
    localparam logic [31:0] REG_CTRL  = 32'h0000_0008;
    localparam logic [31:0] REG_COUNT = 32'h0000_0009;
    localparam logic [31:0] REG_PHASE = 32'h0000_000a;

    // Control register bit positions
    localparam int CTRL_START_BIT = 7;
    localparam int CTRL_DONE_BIT  = 6;
    localparam int CTRL_READY_BIT = 5;
    localparam int CTRL_RESET_BIT = 0;

    // Command words written to the control register
    localparam logic [31:0] CMD_RESET = 32'h1 << CTRL_RESET_BIT;
    localparam logic [31:0] CMD_START = 32'h1 << CTRL_START_BIT;
    localparam logic [31:0] CMD_STOP  = 32'h0000_0000;

    // Sticky error codes presented on error_o
    typedef enum logic [1:0] {
        ERR_NONE         = 2'b00,
        ERR_BUS          = 2'b01,
        ERR_ACK_TIMEOUT  = 2'b10,
        ERR_POLL_TIMEOUT = 2'b11
    } err_code_e;

    // Outcome of one Wishbone transfer
    typedef enum logic [1:0] {
        XFER_OK      = 2'b00,
        XFER_ERR     = 2'b01,
        XFER_TIMEOUT = 2'b10
    } xfer_status_e;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RST       = 4'd1,
        S_WAIT_RDY  = 4'd2,
        S_GO        = 4'd3,
        S_WAIT_DONE = 4'd4,
        S_RD_CNT    = 4'd5,
        S_RD_PH     = 4'd6,
        S_STOP      = 4'd7,
        S_FIN       = 4'd8,
        S_ERR       = 4'd9
    } seq_state_e;

    // True for every state that performs exactly one bus transfer per visit
    // (poll states repeat that transfer after a gap).
    function automatic logic is_bus_state(input seq_state_e s);
        logic r;
        r = 1'b0;
        case (s)
            S_RST, S_WAIT_RDY, S_GO, S_WAIT_DONE,
            S_RD_CNT, S_RD_PH, S_STOP, S_ERR: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// ---------------------------------------------------------------------------
// wb_single_xfer
//
// Runs one Wishbone classic read or write per request, with an ack timeout.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             start a transfer (sampled only while the bus is idle)
//   we, adr, wdat   direction, address and write data of the request
//   done            high in the cycle the transfer ends (ack, err or timeout)
//   rdat            read data, valid while done is high on a read
//   status          ok / err / timeout, valid while done is high
//   bus_*           Wishbone master signals (cyc/stb/adr/dat/we/sel/ack/err)
//
// cyc/stb rise on the edge after req and fall on the edge after the
// response, so back-to-back requests always leave one idle bus cycle.
// ---------------------------------------------------------------------------
module wb_single_xfer
    import freq_meas_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [31:0]  adr,
    input  logic [31:0]  wdat,
    output logic         done,
    output logic [31:0]  rdat,
    output xfer_status_e status,
    output logic [31:0]  bus_adr,
    output logic [31:0]  bus_wdat,
    input  logic [31:0]  bus_rdat,
    output logic         bus_we,
    output logic [3:0]   bus_sel,
    output logic         bus_cyc,
    output logic         bus_stb,
    input  logic         bus_ack,
    input  logic         bus_err
);

    // The timer holds the number of earlier no-response cycles, so the
    // cycle in which it equals ACK_TIMEOUT-1 is the ACK_TIMEOUT-th one.
    localparam logic [15:0] TIMER_LAST = 16'(ACK_TIMEOUT - 1);

    logic        cyc_q;
    logic [15:0] timer;
    logic        timed_out;

    assign bus_cyc = cyc_q;
    assign bus_stb = cyc_q;
    assign rdat    = bus_rdat;

    // Response decode: err has priority over ack, and both over the timeout.
    always_comb begin
        timed_out = cyc_q && (timer == TIMER_LAST);
        done      = cyc_q && (bus_err || bus_ack || timed_out);
        status    = XFER_TIMEOUT;
        if (bus_err) begin
            status = XFER_ERR;
        end else if (bus_ack) begin
            status = XFER_OK;
        end
    end

    // Bus cycle register: launch on req while idle, hold address/data/we
    // constant for the whole cycle, count silent cycles, release on done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q    <= 1'b0;
            bus_adr  <= '0;
            bus_wdat <= '0;
            bus_we   <= 1'b0;
            bus_sel  <= 4'h0;
            timer    <= '0;
        end else if (!cyc_q) begin
            if (req) begin
                cyc_q    <= 1'b1;
                bus_adr  <= adr;
                bus_wdat <= we ? wdat : 32'h0;
                bus_we   <= we;
                bus_sel  <= 4'hF;
                timer    <= '0;
            end
        end else if (done) begin
            cyc_q    <= 1'b0;
            bus_adr  <= '0;
            bus_wdat <= '0;
            bus_we   <= 1'b0;
            bus_sel  <= 4'h0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

endmodule

// File: rtl/freq_meas_sequencer.sv
// ---------------------------------------------------------------------------
// freq_meas_sequencer
//
// Wishbone master that runs one complete measurement on the frequency
// counter slave per accepted start_i: reset, wait ready, start, wait done,
// read count (0x09) and phase (0x0a), stop. Any failure aborts through a
// best-effort stop write and leaves a sticky code on error_o.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           one-cycle request, accepted only while busy_o = 0
//   busy_o            sequence in progress (cycle after start through FIN/ERR)
//   valid_o           one-cycle pulse when count_o/phase_o take new values
//   count_o, phase_o  last successful measurement
//   error_o           00 none, 01 bus error, 10 ack timeout, 11 poll timeout
//   adr_o .. err_i    Wishbone classic master port
// ---------------------------------------------------------------------------
module freq_meas_sequencer
    import freq_meas_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int POLL_LIMIT  = 65535,
    parameter int POLL_GAP    = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] count_o,
    output logic [7:0]  phase_o,
    output logic [1:0]  error_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i
);

    // 17-bit limit so the "count exceeds limit" test also works at 65535.
    localparam logic [16:0] POLL_MAX = 17'(POLL_LIMIT);
    localparam logic [15:0] GAP_INIT = 16'(POLL_GAP);

    seq_state_e   state, state_next;

    logic         xfer_req;
    logic         xfer_we;
    logic [31:0]  xfer_adr;
    logic [31:0]  xfer_wdat;
    logic         xfer_done;
    logic [31:0]  xfer_rdat;
    xfer_status_e xfer_status;

    logic [15:0]  poll_cnt;
    logic [16:0]  poll_sum;
    logic [15:0]  gap_cnt;
    logic [31:0]  cnt_shadow;
    logic [7:0]   ph_shadow;

    logic         err_set;
    logic         err_clr;
    err_code_e    err_code;
    logic         poll_clr;
    logic         poll_inc;
    logic         gap_load;
    logic         cnt_cap;
    logic         ph_cap;
    logic         fin_latch;

    assign busy_o = (state != S_IDLE);

    // A bus state requests its transfer whenever no poll gap is running;
    // the transfer block ignores the request while a cycle is in flight.
    assign xfer_req = is_bus_state(state) && (gap_cnt == 16'd0);

    wb_single_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk      (clk_i),
        .rst      (rst_i),
        .req      (xfer_req),
        .we       (xfer_we),
        .adr      (xfer_adr),
        .wdat     (xfer_wdat),
        .done     (xfer_done),
        .rdat     (xfer_rdat),
        .status   (xfer_status),
        .bus_adr  (adr_o),
        .bus_wdat (dat_o),
        .bus_rdat (dat_i),
        .bus_we   (we_o),
        .bus_sel  (sel_o),
        .bus_cyc  (cyc_o),
        .bus_stb  (stb_o),
        .bus_ack  (ack_i),
        .bus_err  (err_i)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: picks the transfer for the current state and decides
    // what to do when that transfer finishes. A failed transfer sends every
    // state except ERR into ERR; ERR itself always returns to IDLE because
    // its stop write is best effort only.
    always_comb begin
        state_next = state;
        xfer_we    = 1'b0;
        xfer_adr   = REG_CTRL;
        xfer_wdat  = CMD_STOP;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        err_code   = ERR_NONE;
        poll_clr   = 1'b0;
        poll_inc   = 1'b0;
        gap_load   = 1'b0;
        cnt_cap    = 1'b0;
        ph_cap     = 1'b0;
        fin_latch  = 1'b0;
        poll_sum   = {1'b0, poll_cnt} + 17'd1;

        case (state)
            S_RST:       begin xfer_we = 1'b1; xfer_wdat = CMD_RESET; end
            S_GO:        begin xfer_we = 1'b1; xfer_wdat = CMD_START; end
            S_STOP:      begin xfer_we = 1'b1; xfer_wdat = CMD_STOP;  end
            S_ERR:       begin xfer_we = 1'b1; xfer_wdat = CMD_STOP;  end
            S_RD_CNT:    xfer_adr = REG_COUNT;
            S_RD_PH:     xfer_adr = REG_PHASE;
            default:     xfer_adr = REG_CTRL;
        endcase

        if (state == S_IDLE) begin
            if (start_i) begin
                state_next = S_RST;
                err_clr    = 1'b1;
            end
        end else if (state == S_FIN) begin
            state_next = S_IDLE;
        end else if (xfer_done) begin
            if (state == S_ERR) begin
                state_next = S_IDLE;
            end else if (xfer_status == XFER_ERR) begin
                state_next = S_ERR;
                err_set    = 1'b1;
                err_code   = ERR_BUS;
            end else if (xfer_status == XFER_TIMEOUT) begin
                state_next = S_ERR;
                err_set    = 1'b1;
                err_code   = ERR_ACK_TIMEOUT;
            end else begin
                case (state)
                    S_RST: begin
                        state_next = S_WAIT_RDY;
                        poll_clr   = 1'b1;
                    end
                    S_WAIT_RDY: begin
                        if (poll_sum > POLL_MAX) begin
                            state_next = S_ERR;
                            err_set    = 1'b1;
                            err_code   = ERR_POLL_TIMEOUT;
                        end else if (xfer_rdat[CTRL_READY_BIT]) begin
                            state_next = S_GO;
                        end else begin
                            poll_inc = 1'b1;
                            gap_load = 1'b1;
                        end
                    end
                    S_GO: begin
                        state_next = S_WAIT_DONE;
                        poll_clr   = 1'b1;
                    end
                    S_WAIT_DONE: begin
                        if (poll_sum > POLL_MAX) begin
                            state_next = S_ERR;
                            err_set    = 1'b1;
                            err_code   = ERR_POLL_TIMEOUT;
                        end else if (xfer_rdat[CTRL_DONE_BIT]) begin
                            state_next = S_RD_CNT;
                        end else begin
                            poll_inc = 1'b1;
                            gap_load = 1'b1;
                        end
                    end
                    S_RD_CNT: begin
                        state_next = S_RD_PH;
                        cnt_cap    = 1'b1;
                    end
                    S_RD_PH: begin
                        state_next = S_STOP;
                        ph_cap     = 1'b1;
                    end
                    S_STOP: begin
                        state_next = S_FIN;
                        fin_latch  = 1'b1;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
        end
    end

    // Poll bookkeeping: the read counter restarts on entry to each poll
    // state, and a missed poll holds off the next read for POLL_GAP cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (poll_clr) begin
                poll_cnt <= '0;
            end else if (poll_inc) begin
                poll_cnt <= poll_sum[15:0];
            end
            if (gap_load) begin
                gap_cnt <= GAP_INIT;
            end else if (gap_cnt != 16'd0) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

    // Results: reads land in shadows first so an aborted sequence never
    // disturbs the published count/phase. Both outputs and valid_o change
    // on the edge into FIN, so they are seen together in the FIN cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_shadow <= '0;
            ph_shadow  <= '0;
            count_o    <= '0;
            phase_o    <= '0;
            valid_o    <= 1'b0;
            error_o    <= ERR_NONE;
        end else begin
            valid_o <= fin_latch;
            if (cnt_cap) begin
                cnt_shadow <= xfer_rdat;
            end
            if (ph_cap) begin
                ph_shadow <= xfer_rdat[7:0];
            end
            if (fin_latch) begin
                count_o <= cnt_shadow;
                phase_o <= ph_shadow;
            end
            if (err_clr) begin
                error_o <= ERR_NONE;
            end else if (err_set) begin
                error_o <= err_code;
            end
        end
    end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_freq_meas_sequencer
//
// Directed bench for freq_meas_sequencer with a behavioural zero-wait
// Wishbone slave that can withhold one write ack, raise err on one address,
// and report done after a programmable number of control reads.
// ---------------------------------------------------------------------------
module tb_freq_meas_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] count_o;
    logic [7:0]  phase_o;
    logic [1:0]  error_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Slave configuration (written by the stimulus block)
    logic [31:0] reg9;
    logic [31:0] rega;
    int          done_after;
    logic        rdy_bit;
    int          drop_limit;
    int          err_limit;
    logic [31:0] err_adr;

    // Slave bookkeeping (written only by the slave model)
    int          drops_done = 0;
    int          errs_done  = 0;
    int          done_reads = 0;
    int          viol       = 0;
    logic        in_drop    = 1'b0;
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    int          valid_count = 0;

    int wr_base;
    int v_base;
    int n;
    int hi;

    freq_meas_sequencer #(
        .ACK_TIMEOUT (8),
        .POLL_LIMIT  (4),
        .POLL_GAP    (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .count_o (count_o),
        .phase_o (phase_o),
        .error_o (error_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .we_o    (we_o),
        .sel_o   (sel_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .ack_i   (ack_i),
        .err_i   (err_i)
    );

    always #5 clk_i = ~clk_i;

    // Zero-wait slave: responds on the edge after it first sees stb, logs
    // every acked write, and counts control reads since the last start write.
    always @(posedge clk_i) begin
        ack_i <= 1'b0;
        err_i <= 1'b0;
        dat_i <= 32'h0;
        if (!cyc_o && in_drop) begin
            in_drop    <= 1'b0;
            drops_done <= drops_done + 1;
        end
        if (cyc_o && stb_o && !ack_i && !err_i && !in_drop) begin
            if (sel_o != 4'hF || (!we_o && dat_o != 32'h0)) begin
                viol <= viol + 1;
            end
            if (we_o && drops_done < drop_limit) begin
                in_drop <= 1'b1;
            end else if (adr_o == err_adr && errs_done < err_limit) begin
                err_i     <= 1'b1;
                errs_done <= errs_done + 1;
            end else begin
                ack_i <= 1'b1;
                if (we_o) begin
                    wr_adr_q.push_back(adr_o);
                    wr_dat_q.push_back(dat_o);
                    if (adr_o == 32'h8 && dat_o == 32'h80) begin
                        done_reads <= 0;
                    end
                end else if (adr_o == 32'h8) begin
                    done_reads <= done_reads + 1;
                    dat_i <= {24'h0, 1'b0,
                              ((done_after != 0) && (done_reads + 1 >= done_after)),
                              rdy_bit, 5'h0};
                end else if (adr_o == 32'h9) begin
                    dat_i <= reg9;
                end else if (adr_o == 32'ha) begin
                    dat_i <= rega;
                end
            end
        end
    end

    // Count valid pulses away from the active edge.
    always @(negedge clk_i) begin
        if (valid_o) begin
            valid_count <= valid_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse driven between active edges.
    task automatic applyStimulus();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int k;
        k = 0;
        while (busy_o && k < 400) begin
            @(negedge clk_i);
            k++;
        end
        checkOutput({tag, "_idle"}, {31'h0, busy_o}, 32'h0);
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        reg9       = 32'h0001_86A0;
        rega       = 32'h0000_0003;
        done_after = 3;
        rdy_bit    = 1'b1;
        drop_limit = 0;
        err_limit  = 0;
        err_adr    = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) @(negedge clk_i);
        checkOutput("rst_busy",  {31'h0, busy_o},  32'h0);
        checkOutput("rst_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("rst_count", count_o, 32'h0);
        checkOutput("rst_phase", {24'h0, phase_o}, 32'h0);
        checkOutput("rst_error", {30'h0, error_o}, 32'h0);
        checkOutput("rst_bus",   {25'h0, cyc_o, stb_o, we_o, sel_o}, 32'h0);
        checkOutput("rst_adr",   adr_o, 32'h0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Normal measurement: done on the third control read
        $display("[TB] normal measurement");
        wr_base = wr_dat_q.size();
        v_base  = valid_count;
        applyStimulus();
        checkOutput("run1_busy", {31'h0, busy_o}, 32'h1);
        waitIdle("run1");
        repeat (3) @(negedge clk_i);
        checkOutput("run1_valid_pulses", valid_count - v_base, 32'd1);
        checkOutput("run1_count", count_o, 32'h0001_86A0);
        checkOutput("run1_phase", {24'h0, phase_o}, 32'h3);
        checkOutput("run1_error", {30'h0, error_o}, 32'h0);
        checkOutput("run1_writes", wr_dat_q.size() - wr_base, 32'd3);
        checkOutput("run1_wr0", wr_dat_q[wr_base],     32'h01);
        checkOutput("run1_wr1", wr_dat_q[wr_base + 1], 32'h80);
        checkOutput("run1_wr2", wr_dat_q[wr_base + 2], 32'h00);
        checkOutput("run1_wradr", wr_adr_q[wr_base] | wr_adr_q[wr_base + 1] | wr_adr_q[wr_base + 2], 32'h08);
        checkOutput("run1_done_reads", done_reads, 32'd3);

        // Ack timeout on the reset write
        $display("[TB] ack timeout");
        wr_base    = wr_dat_q.size();
        v_base     = valid_count;
        drop_limit = drops_done + 1;
        applyStimulus();
        n = 0;
        while (!stb_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        hi = 0;
        while (stb_o && hi < 100) begin
            hi++;
            @(negedge clk_i);
        end
        checkOutput("to_stb_cycles", hi, 32'd8);
        waitIdle("to");
        checkOutput("to_error", {30'h0, error_o}, 32'h2);
        checkOutput("to_valid_pulses", valid_count - v_base, 32'd0);
        checkOutput("to_count_kept", count_o, 32'h0001_86A0);
        checkOutput("to_cleanup_writes", wr_dat_q.size() - wr_base, 32'd1);
        checkOutput("to_cleanup_data", wr_dat_q[wr_base], 32'h0);

        // Bus error on the count read
        $display("[TB] bus error on count read");
        wr_base   = wr_dat_q.size();
        v_base    = valid_count;
        reg9      = 32'h1234_5678;
        err_adr   = 32'h9;
        err_limit = errs_done + 1;
        applyStimulus();
        checkOutput("be_error_cleared", {30'h0, error_o}, 32'h0);
        waitIdle("be");
        checkOutput("be_error", {30'h0, error_o}, 32'h1);
        checkOutput("be_count_kept", count_o, 32'h0001_86A0);
        checkOutput("be_phase_kept", {24'h0, phase_o}, 32'h3);
        checkOutput("be_valid_pulses", valid_count - v_base, 32'd0);
        checkOutput("be_writes", wr_dat_q.size() - wr_base, 32'd3);
        checkOutput("be_cleanup_data", wr_dat_q[wr_base + 2], 32'h0);
        checkOutput("be_cleanup_adr", wr_adr_q[wr_base + 2], 32'h8);

        // Done never set: poll limit of 4 allows five reads then fails
        $display("[TB] poll timeout");
        v_base     = valid_count;
        done_after = 0;
        applyStimulus();
        waitIdle("pt");
        checkOutput("pt_error", {30'h0, error_o}, 32'h3);
        checkOutput("pt_done_reads", done_reads, 32'd5);
        checkOutput("pt_valid_pulses", valid_count - v_base, 32'd0);
        checkOutput("pt_count_kept", count_o, 32'h0001_86A0);

        // Second start while busy is dropped
        $display("[TB] start while busy");
        wr_base    = wr_dat_q.size();
        v_base     = valid_count;
        done_after = 1;
        reg9       = 32'hCAFE_0001;
        rega       = 32'hABCD_12A5;
        applyStimulus();
        repeat (5) @(negedge clk_i);
        applyStimulus();
        waitIdle("sb");
        repeat (40) @(negedge clk_i);
        checkOutput("sb_busy_after", {31'h0, busy_o}, 32'h0);
        checkOutput("sb_valid_pulses", valid_count - v_base, 32'd1);
        checkOutput("sb_writes", wr_dat_q.size() - wr_base, 32'd3);
        checkOutput("sb_count", count_o, 32'hCAFE_0001);
        checkOutput("sb_phase", {24'h0, phase_o}, 32'hA5);
        checkOutput("sb_error", {30'h0, error_o}, 32'h0);

        // Asynchronous reset in the middle of a bus cycle
        $display("[TB] reset mid-cycle");
        applyStimulus();
        n = 0;
        while (!cyc_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("ar_cyc_seen", {31'h0, cyc_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("ar_bus", {25'h0, cyc_o, stb_o, we_o, sel_o}, 32'h0);
        checkOutput("ar_busy", {31'h0, busy_o}, 32'h0);
        checkOutput("ar_count", count_o, 32'h0);
        checkOutput("ar_phase_err_valid", {22'h0, phase_o, error_o, valid_o}, 32'h0);
        wr_base = wr_dat_q.size();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        checkOutput("ar_no_cleanup", wr_dat_q.size() - wr_base, 32'd0);
        checkOutput("ar_cyc_after", {31'h0, cyc_o}, 32'h0);

        checkOutput("protocol_violations", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
